// File: rtl/exp_mu_pkg.sv
// Shared constants and state encoding for the exp(-mu*s*k) table generator.
// Build option: EXPMU_ROUNDING_EN selects round-half-up on every product shift.
package exp_mu_pkg;
  localparam int DATA_W      = 18;
  localparam int ADDR_W      = 9;
  localparam int PROD_W      = 2 * DATA_W;
  localparam int SH_W        = 5;
  localparam int TABLE_DEPTH = 512;

  localparam logic [DATA_W:0]   ONE_Q18  = 19'd262144;
  localparam logic [DATA_W-1:0] ONE_Q17  = 18'd131072;
  localparam logic [DATA_W-1:0] INV6_Q18 = 18'd43691;
  localparam logic [DATA_W-1:0] MAX_Q18  = 18'd262143;

  // Half-LSB added ahead of the final >>1 steps done outside the multiplier.
`ifdef EXPMU_ROUNDING_EN
  localparam logic [DATA_W:0] HALF_LSB = 19'd1;
`else
  localparam logic [DATA_W:0] HALF_LSB = 19'd0;
`endif

  typedef enum logic [2:0] {
    IDLE, MUL_X, SQ, CUBE, BASE, RUN, DONE
  } state_t;
endpackage

// File: rtl/expmu_fxmul.sv
// 18x18 unsigned multiply followed by a variable right shift.
// Ports: a_i, b_i operands; sh_i shift amount; p_o shifted 36-bit product.
// Build option: EXPMU_ROUNDING_EN adds half an output LSB before shifting.
module expmu_fxmul
  import exp_mu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [SH_W-1:0]   sh_i,
  output logic [PROD_W-1:0] p_o
);
  logic [PROD_W-1:0] prod;

  always_comb begin
    prod = PROD_W'(a_i) * PROD_W'(b_i);
`ifdef EXPMU_ROUNDING_EN
    // Max product plus 2^17 still fits in 36 bits, so no carry-out to handle.
    if (sh_i != '0) prod = prod + (PROD_W'(1) << (sh_i - SH_W'(1)));
`endif
    p_o = prod >> sh_i;
  end
endmodule

// File: rtl/calculate_exp_mu.sv
// Streams oData[k] = exp(-mu*s*k), k = 0..511, as Q1.17 for a downstream RAM.
// The base factor comes from a 3-term Taylor series; entries are successive
// powers obtained by repeated multiplication on one shared multiplier.
// Ports: CLK, RSTn (sync, active low); iMu Q0.18, iS Q3.15, iStart pulse;
//        oData Q1.17, oAddr index, oValid strobe, oDone one-cycle end pulse.
// Build option: EXPMU_ROUNDING_EN selects round-half-up instead of truncation.
module calculate_exp_mu
  import exp_mu_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [DATA_W-1:0] iMu,
  input  logic [DATA_W-1:0] iS,
  input  logic              iStart,
  output logic [DATA_W-1:0] oData,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oValid,
  output logic              oDone
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] mu_q, s_q, x_q, x2_q, x3_q, r_q, acc_q;
  logic [ADDR_W-1:0] k_q;

  logic [DATA_W-1:0] mul_a, mul_b;
  logic [SH_W-1:0]   mul_sh;
  logic [PROD_W-1:0] mul_p;
  logic [DATA_W-1:0] x_sat;
  logic [DATA_W:0]   x2_half, r18, r18_rnd;
  logic [DATA_W-1:0] r_d;
  logic              last_k;

  expmu_fxmul u_mul (.a_i(mul_a), .b_i(mul_b), .sh_i(mul_sh), .p_o(mul_p));

  // Operand steering: each state owns the multiplier for its one product.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    mul_sh = '0;
    case (state_q)
      MUL_X: begin mul_a = mu_q;  mul_b = s_q;      mul_sh = SH_W'(15); end
      SQ:    begin mul_a = x_q;   mul_b = x_q;      mul_sh = SH_W'(18); end
      CUBE:  begin mul_a = x2_q;  mul_b = x_q;      mul_sh = SH_W'(18); end
      BASE:  begin mul_a = x3_q;  mul_b = INV6_Q18; mul_sh = SH_W'(18); end
      RUN:   begin mul_a = acc_q; mul_b = r_q;      mul_sh = SH_W'(17); end
      default: ;
    endcase
  end

  // mu*s can reach ~2^21 after >>15; saturate to the largest Q0.18 value.
  assign x_sat = (|mul_p[PROD_W-1:DATA_W]) ? MAX_Q18 : mul_p[DATA_W-1:0];

  // r18 = 1 - x + x^2/2 - x^3/6 in Q1.18. Intermediates may wrap mod 2^19,
  // but the final value is always within 0..262144.
  always_comb begin
    x2_half = (DATA_W+1)'({1'b0, x2_q} + HALF_LSB) >> 1;
    r18     = ONE_Q18 - {1'b0, x_q} + x2_half - {1'b0, mul_p[DATA_W-1:0]};
    r18_rnd = r18 + HALF_LSB;
    r_d     = DATA_W'(r18_rnd >> 1);
  end

  assign last_k = (k_q == ADDR_W'(TABLE_DEPTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = MUL_X;
      MUL_X:   state_d = SQ;
      SQ:      state_d = CUBE;
      CUBE:    state_d = BASE;
      BASE:    state_d = RUN;
      RUN:     if (last_k) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      mu_q    <= '0;
      s_q     <= '0;
      x_q     <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:  if (iStart) begin mu_q <= iMu; s_q <= iS; end
        MUL_X: x_q  <= x_sat;
        SQ:    x2_q <= mul_p[DATA_W-1:0];
        CUBE:  x3_q <= mul_p[DATA_W-1:0];
        BASE: begin
          r_q   <= r_d;
          acc_q <= ONE_Q17;
          k_q   <= '0;
        end
        // The last entry is left on oData/oAddr so they hold afterwards.
        RUN: if (!last_k) begin
          acc_q <= mul_p[DATA_W-1:0];
          k_q   <= k_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign oData  = acc_q;
  assign oAddr  = k_q;
  assign oValid = (state_q == RUN);
  assign oDone  = (state_q == DONE);
endmodule

// File: tb/tb_calculate_exp_mu.sv
module tb_calculate_exp_mu;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [17:0] iMu = '0;
  logic [17:0] iS = '0;
  logic        iStart = 1'b0;
  logic [17:0] oData;
  logic [8:0]  oAddr;
  logic        oValid;
  logic        oDone;

  int errs = 0;
  int checks = 0;
  longint tab [512];

  calculate_exp_mu dut (
    .CLK(CLK), .RSTn(RSTn), .iMu(iMu), .iS(iS), .iStart(iStart),
    .oData(oData), .oAddr(oAddr), .oValid(oValid), .oDone(oDone)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint shr(input longint p, input int sh);
`ifdef EXPMU_ROUNDING_EN
    return (p + (longint'(1) << (sh - 1))) >> sh;
`else
    return p >> sh;
`endif
  endfunction

  // Reference table straight from the arithmetic definition.
  task automatic build_model(input longint mu, input longint s);
    longint x, x2, x3, r18, r;
    x = shr(mu * s, 15);
    if (x > 262143) x = 262143;
    x2  = shr(x * x, 18);
    x3  = shr(x2 * x, 18);
    r18 = 262144 - x + shr(x2, 1) - shr(x3 * 43691, 18);
    r   = shr(r18, 1);
    tab[0] = 131072;
    for (int k = 1; k < 512; k++) tab[k] = shr(tab[k-1] * r, 17);
  endtask

  // mode 0: plain, 1: inputs scrambled after start, 2: extra start mid-RUN,
  // 3: reset while oAddr = 100.
  task automatic run_one(input logic [17:0] mu, input logic [17:0] s, input int mode,
                         output longint d1, output longint d2, output longint dlast);
    d1 = -1; d2 = -1; dlast = -1;
    build_model(mu, s);
    @(negedge CLK);
    iMu = mu; iS = s; iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    if (mode == 1) begin iMu = 18'($urandom); iS = 18'($urandom); end
    for (int cyc = 1; cyc <= 518; cyc++) begin
      if (cyc >= 5 && cyc <= 516) begin
        chk("valid_run", oValid, 1);
        chk("addr", oAddr, cyc - 5);
        chk("data", oData, tab[cyc-5]);
        if (cyc == 6) d1 = oData;
        if (cyc == 7) d2 = oData;
        if (cyc == 516) dlast = oData;
      end else begin
        chk("valid_idle", oValid, 0);
      end
      chk("done", oDone, (cyc == 517) ? 1 : 0);
      if (cyc == 518) chk("addr_hold", oAddr, 511);
      if (mode == 2 && cyc == 200) iStart = 1'b1;
      if (mode == 2 && cyc == 201) iStart = 1'b0;
      if (mode == 3 && cyc == 105) begin
        RSTn = 1'b0;
        @(negedge CLK);
        chk("abort_data", oData, 0);
        chk("abort_addr", oAddr, 0);
        chk("abort_valid", oValid, 0);
        chk("abort_done", oDone, 0);
        RSTn = 1'b1;
        for (int j = 0; j < 420; j++) begin
          @(negedge CLK);
          if (oDone !== 1'b0 || oValid !== 1'b0) chk("abort_quiet", {oDone, oValid}, 0);
        end
        chk("abort_quiet_end", {oDone, oValid}, 0);
        return;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    longint d1, d2, dl;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_data", oData, 0);
    chk("rst_addr", oAddr, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_done", oDone, 0);
    RSTn = 1'b1;

    run_one(18'd184, 18'd24576, 0, d1, d2, dl);
    chk("known_addr1", d1, 131003);
    chk("known_addr2", d2, 130934);

    run_one(18'd0, 18'($urandom), 0, d1, d2, dl);
    chk("mu0_last", dl, 131072);

    run_one(18'd262143, 18'd262143, 0, d1, d2, dl);
    chk("max_last_zero", dl, 0);

    run_one(18'd184, 18'd24576, 2, d1, d2, dl);
    run_one(18'($urandom), 18'($urandom), 3, d1, d2, dl);
    run_one(18'd184, 18'd24576, 0, d1, d2, dl);
    chk("after_abort_addr1", d1, 131003);
    run_one(18'd184, 18'd24576, 1, d1, d2, dl);
    chk("scramble_addr2", d2, 130934);

    for (int n = 0; n < 3; n++)
      run_one(18'($urandom_range(0, 262143)), 18'($urandom_range(0, 262143)), 0, d1, d2, dl);
    run_one(18'($urandom_range(0, 2047)), 18'($urandom_range(0, 65535)), 0, d1, d2, dl);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
